// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: latches memory-stage results and drives the register-file writeback.
// Optional stall-cycle counter enabled by defining MEM_WB_PERF_EN.
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              stall,
    input  logic              flush,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              memtoReg_in,
    input  logic              jal_in,
    input  logic              regWrite_in,
    input  logic [REG_W-1:0]  regSel_in,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] aluOut_in,
    input  logic [DATA_W-1:0] dmemload_in,
    input  logic              halt_in,
    output logic              regWrite_out,
    output logic [REG_W-1:0]  regSel_out,
    output logic [DATA_W-1:0] wdat_out,
    output logic              halt_out,
    output logic              valid_out,
    output logic              mem_wait_out,
    output logic [31:0]       perf_memstall
);

    logic              mem_op;
    logic              advance;

    logic              valid_q,    valid_d;
    logic              regWrite_q, regWrite_d;
    logic              halt_q,     halt_d;
    logic              memtoReg_q, memtoReg_d;
    logic              jal_q,      jal_d;
    logic [REG_W-1:0]  regSel_q,   regSel_d;
    logic [DATA_W-1:0] npc_q,      npc_d;
    logic [DATA_W-1:0] aluOut_q,   aluOut_d;
    logic [DATA_W-1:0] dmemload_q, dmemload_d;

    assign mem_op  = memRead_in | memWrite_in;
    // Memory ops advance on the data-cache strobe; everything else on the fetch strobe.
    assign advance = ~stall & ~halt_q & (mem_op ? dhit : ihit);

    always_comb begin
        valid_d    = valid_q;
        regWrite_d = regWrite_q;
        halt_d     = halt_q;
        memtoReg_d = memtoReg_q;
        jal_d      = jal_q;
        regSel_d   = regSel_q;
        npc_d      = npc_q;
        aluOut_d   = aluOut_q;
        dmemload_d = dmemload_q;
        if (!halt_q) begin
            if (flush) begin
                valid_d    = 1'b0;
                regWrite_d = 1'b0;
                halt_d     = 1'b0;
                memtoReg_d = 1'b0;
                jal_d      = 1'b0;
            end else if (advance) begin
                valid_d    = 1'b1;
                regWrite_d = regWrite_in;
                halt_d     = halt_in;
                memtoReg_d = memtoReg_in;
                jal_d      = jal_in;
                regSel_d   = regSel_in;
                npc_d      = npc_in;
                aluOut_d   = aluOut_in;
                // A load only advances on dhit, so its data is valid here.
                if (memRead_in) begin
                    dmemload_d = dmemload_in;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q    <= 1'b0;
            regWrite_q <= 1'b0;
            halt_q     <= 1'b0;
            memtoReg_q <= 1'b0;
            jal_q      <= 1'b0;
            regSel_q   <= '0;
            npc_q      <= '0;
            aluOut_q   <= '0;
            dmemload_q <= '0;
        end else begin
            valid_q    <= valid_d;
            regWrite_q <= regWrite_d;
            halt_q     <= halt_d;
            memtoReg_q <= memtoReg_d;
            jal_q      <= jal_d;
            regSel_q   <= regSel_d;
            npc_q      <= npc_d;
            aluOut_q   <= aluOut_d;
            dmemload_q <= dmemload_d;
        end
    end

    assign regWrite_out = valid_q & regWrite_q & ~halt_q;
    assign regSel_out   = regSel_q;
    assign halt_out     = halt_q;
    assign valid_out    = valid_q;
    assign mem_wait_out = mem_op & ~dhit & ~halt_q;
    assign wdat_out     = jal_q ? npc_q : (memtoReg_q ? dmemload_q : aluOut_q);

`ifdef MEM_WB_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of cycles spent waiting on the data cache.
    always_comb begin
        perf_d = perf_q;
        if (mem_wait_out && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_memstall = perf_q;
`else
    assign perf_memstall = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Randomized bench for mem_wb_reg with a behavioural writeback model and directed anchor checks.
module tb_mem_wb_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ihit, dhit, stall, flush;
    logic              memRead_in, memWrite_in, memtoReg_in, jal_in, regWrite_in, halt_in;
    logic [REG_W-1:0]  regSel_in;
    logic [DATA_W-1:0] npc_in, aluOut_in, dmemload_in;
    logic              regWrite_out, halt_out, valid_out, mem_wait_out;
    logic [REG_W-1:0]  regSel_out;
    logic [DATA_W-1:0] wdat_out;
    logic [31:0]       perf_memstall;

    mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .stall(stall), .flush(flush),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in),
        .jal_in(jal_in), .regWrite_in(regWrite_in), .regSel_in(regSel_in),
        .npc_in(npc_in), .aluOut_in(aluOut_in), .dmemload_in(dmemload_in),
        .halt_in(halt_in), .regWrite_out(regWrite_out), .regSel_out(regSel_out),
        .wdat_out(wdat_out), .halt_out(halt_out), .valid_out(valid_out),
        .mem_wait_out(mem_wait_out), .perf_memstall(perf_memstall)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the instruction currently held for writeback.
    bit              m_valid, m_wr, m_halt, m_m2r, m_jal;
    logic [REG_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_npc, m_alu, m_load;
    logic [31:0]       m_perf;

    initial begin
        m_valid = 0; m_wr = 0; m_halt = 0; m_m2r = 0; m_jal = 0;
        m_sel = '0; m_npc = '0; m_alu = '0; m_load = '0; m_perf = '0;
    end

    function automatic bit exp_memwait();
        return (memRead_in || memWrite_in) && !dhit && !m_halt;
    endfunction

    always @(posedge CLK) begin
        bit is_mem, go, waiting;
        is_mem  = memRead_in || memWrite_in;
        waiting = exp_memwait();
        go      = !stall && (is_mem ? dhit : ihit);
        if (RST) begin
            m_valid = 0; m_wr = 0; m_halt = 0; m_m2r = 0; m_jal = 0;
            m_sel = '0; m_npc = '0; m_alu = '0; m_load = '0; m_perf = '0;
        end else if (!m_halt) begin
            if (waiting && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
            if (flush) begin
                m_valid = 0; m_wr = 0; m_halt = 0; m_m2r = 0; m_jal = 0;
            end else if (go) begin
                m_valid = 1; m_wr = regWrite_in; m_halt = halt_in;
                m_m2r = memtoReg_in; m_jal = jal_in; m_sel = regSel_in;
                m_npc = npc_in; m_alu = aluOut_in;
                if (memRead_in) m_load = dmemload_in;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [DATA_W-1:0] e_wdat;
            e_wdat = m_jal ? m_npc : (m_m2r ? m_load : m_alu);
            chk("valid_out", 64'(valid_out), 64'(m_valid));
            chk("halt_out", 64'(halt_out), 64'(m_halt));
            chk("regWrite_out", 64'(regWrite_out), 64'(m_valid && m_wr && !m_halt));
            chk("regSel_out", 64'(regSel_out), 64'(m_sel));
            chk("wdat_out", 64'(wdat_out), 64'(e_wdat));
            chk("mem_wait_out", 64'(mem_wait_out), 64'(exp_memwait()));
`ifdef MEM_WB_PERF_EN
            chk("perf_memstall", 64'(perf_memstall), 64'(m_perf));
`else
            chk("perf_memstall", 64'(perf_memstall), 64'd0);
`endif
        end
    end

    task automatic clear_in();
        ihit = 0; dhit = 0; stall = 0; flush = 0;
        memRead_in = 0; memWrite_in = 0; memtoReg_in = 0; jal_in = 0;
        regWrite_in = 0; halt_in = 0; regSel_in = '0;
        npc_in = '0; aluOut_in = '0; dmemload_in = '0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1;
        clear_in();
        cyc();
        chk_en = 1;
        cyc();
        RST = 0;
        cyc();
        chk("reset valid", 64'(valid_out), 64'd0);
        chk("reset wdat", 64'(wdat_out), 64'd0);
        chk("reset regWrite", 64'(regWrite_out), 64'd0);

        // ALU op
        regWrite_in = 1; regSel_in = 5'd8; aluOut_in = 32'h1234; ihit = 1;
        cyc();
        clear_in();
        chk("alu regSel", 64'(regSel_out), 64'd8);
        chk("alu wdat", 64'(wdat_out), 64'h1234);
        chk("alu regWrite", 64'(regWrite_out), 64'd1);

        // Load waiting three cycles on dhit
        memRead_in = 1; memtoReg_in = 1; regWrite_in = 1; regSel_in = 5'd3;
        dmemload_in = 32'hDEADBEEF;
        #1;
        chk("load mem_wait", 64'(mem_wait_out), 64'd1);
        repeat (3) cyc();
        chk("load held wdat", 64'(wdat_out), 64'h1234);
        dhit = 1;
        cyc();
        clear_in();
        chk("load wdat", 64'(wdat_out), 64'hDEADBEEF);
`ifdef MEM_WB_PERF_EN
        chk("load perf", 64'(perf_memstall), 64'd3);
`endif

        // jal beats memtoReg
        jal_in = 1; memtoReg_in = 1; npc_in = 32'h40; ihit = 1; regWrite_in = 1; regSel_in = 5'd31;
        cyc();
        clear_in();
        chk("jal wdat", 64'(wdat_out), 64'h40);

        // flush beats advance
        flush = 1; ihit = 1; regWrite_in = 1; regSel_in = 5'd5; aluOut_in = 32'h999;
        cyc();
        clear_in();
        chk("flush valid", 64'(valid_out), 64'd0);
        chk("flush regWrite", 64'(regWrite_out), 64'd0);
        chk("flush regSel kept", 64'(regSel_out), 64'd31);

        // Sticky halt
        halt_in = 1; ihit = 1; regWrite_in = 1; regSel_in = 5'd9;
        cyc();
        clear_in();
        for (int i = 0; i < 6; i++) begin
            ihit = i[0]; flush = i[1]; regWrite_in = 1; regSel_in = 5'(i + 1);
            aluOut_in = 32'(i * 7);
            cyc();
        end
        clear_in();
        chk("halt held", 64'(halt_out), 64'd1);
        chk("halt regWrite", 64'(regWrite_out), 64'd0);
        chk("halt regSel frozen", 64'(regSel_out), 64'd9);
        RST = 1;
        cyc();
        RST = 0;
        chk("halt cleared", 64'(halt_out), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 79) == 0);
            ihit        = $urandom_range(0, 1);
            dhit        = ($urandom_range(0, 2) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            memRead_in  = ($urandom_range(0, 2) == 0);
            memWrite_in = ($urandom_range(0, 4) == 0);
            memtoReg_in = $urandom_range(0, 1);
            jal_in      = ($urandom_range(0, 5) == 0);
            regWrite_in = $urandom_range(0, 1);
            halt_in     = ($urandom_range(0, 99) == 0);
            regSel_in   = 5'($urandom);
            npc_in      = $urandom;
            aluOut_in   = $urandom;
            dmemload_in = $urandom;
            cyc();
        end
        clear_in();
        RST = 1;
        cyc();
        RST = 0;
        cyc();
        @(negedge CLK);
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
